// File: rtl/bcd_code_source_if.sv
// Handshake bundle between the BCD code source and its consumer.
// The master modport belongs to the source; the slave modport belongs to the consumer or controller.
interface bcd_code_source_if;
  logic       start;
  logic       stop;
  logic       sweep;
  logic       up_dn;
  logic       ld;
  logic [3:0] ld_val;
  logic       ready;
  logic [3:0] code;
  logic       valid;
  logic       tc;
  logic       done;

  modport master (
    input  start, stop, sweep, up_dn, ld, ld_val, ready,
    output code, valid, tc, done
  );

  modport slave (
    output start, stop, sweep, up_dn, ld, ld_val, ready,
    input  code, valid, tc, done
  );
endinterface

// File: rtl/bcd_code_source.sv
// Steps a BCD code through 0..MAX_CODE, up or down, with a programmable dwell.
// Each code is offered to the downstream minimization stage through a valid/ready handshake.
module bcd_code_source #(
  parameter int DWELL    = 10,
  parameter int MAX_CODE = 9
) (
  input  logic               clk,
  input  logic               rst,
  bcd_code_source_if.master  bus
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] CODE_MAX   = 4'(MAX_CODE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] presc_q, presc_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       terminal;

  function automatic logic [3:0] sat_code(input logic [3:0] v);
    return (v > CODE_MAX) ? CODE_MAX : v;
  endfunction

  // Wrap is an explicit compare so non-power-of-two ranges never rely on 4-bit overflow.
  function automatic logic [3:0] step_code(input logic [3:0] c, input logic up);
    if (up) return (c >= CODE_MAX) ? 4'd0 : c + 4'd1;
    else    return (c == 4'd0) ? CODE_MAX : c - 4'd1;
  endfunction

  assign terminal = bus.up_dn ? (code_q == CODE_MAX) : (code_q == 4'd0);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    presc_d = presc_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (bus.ld) code_d = sat_code(bus.ld_val);
          if (bus.start) begin
            state_d = ST_RUN;
            presc_d = 8'd0;
          end
        end
        ST_RUN: begin
          valid_d = 1'b0;
          if (presc_q == DWELL_LAST) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            presc_d = 8'd0;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (valid_q && bus.ready) begin
            code_d  = step_code(code_q, bus.up_dn);
            valid_d = 1'b0;
            presc_d = 8'd0;
            if (bus.sweep && terminal) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= 4'd0;
      presc_q <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      presc_q <= presc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
  assign bus.tc    = terminal;

endmodule

// File: tb/tb_bcd_code_source.sv
// Directed bench for bcd_code_source: a countdown-style reference model is checked every cycle,
// and literal expectations for each scenario pin that model.
module tb_bcd_code_source;
  localparam int DWELL = 10;
  localparam int MAXC  = 9;

  logic clk = 1'b0;
  logic rst;
  bcd_code_source_if bus ();

  bcd_code_source #(.DWELL(DWELL), .MAX_CODE(MAXC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether a sweep is active, how many edges remain until the
  // next presentation, and the code value, all in plain modulo arithmetic.
  int m_code = 0;
  bit m_busy = 0;
  bit m_valid = 0;
  bit m_done = 0;
  int m_wait = 0;

  task automatic model_step();
    int old;
    if (rst) begin
      m_code = 0; m_busy = 0; m_valid = 0; m_done = 0; m_wait = 0;
    end else begin
      m_done = 0;
      if (bus.stop) begin
        m_busy = 0; m_valid = 0;
      end else if (!m_busy) begin
        if (bus.ld) m_code = (int'(bus.ld_val) > MAXC) ? MAXC : int'(bus.ld_val);
        if (bus.start) begin m_busy = 1; m_wait = DWELL; end
      end else if (!m_valid) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) m_valid = 1;
      end else if (bus.ready) begin
        old = m_code;
        m_code = bus.up_dn ? (m_code + 1) % (MAXC + 1) : (m_code + MAXC) % (MAXC + 1);
        m_valid = 0;
        if (bus.sweep && (bus.up_dn ? old == MAXC : old == 0)) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_wait = DWELL;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("model code",  int'(bus.code),  m_code);
    check("model valid", int'(bus.valid), int'(m_valid));
    check("model done",  int'(bus.done),  int'(m_done));
    check("model tc",    int'(bus.tc),    int'(bus.up_dn ? (m_code == MAXC) : (m_code == 0)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n = 0;
    while (bus.valid != 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_lat > 0) check({name, " latency"}, n, exp_lat);
    else             check({name, " timeout"}, int'(n < 300), 1);
  endtask

  int exp_up [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_dn [3]  = '{2, 1, 0};

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.stop = 0; bus.sweep = 0; bus.up_dn = 1;
    bus.ld = 0; bus.ld_val = 4'd0; bus.ready = 0;
    step(2);
    rst = 1'b0;
    check("reset code", int'(bus.code), 0);
    check("reset valid", int'(bus.valid), 0);

    // Continuous up count
    bus.ready = 1; bus.start = 1;
    step(1);
    bus.start = 0;
    wait_valid("first", DWELL);
    check("first code", int'(bus.code), 0);
    for (int i = 0; i < 11; i++) begin
      step(1);
      check("accept drops valid", int'(bus.valid), 0);
      wait_valid("up", DWELL);
      check("up code", int'(bus.code), exp_up[i]);
    end
    bus.stop = 1;
    step(1);
    bus.stop = 0;
    check("stop1 valid", int'(bus.valid), 0);
    check("stop1 code", int'(bus.code), 1);

    // Single sweep down with simultaneous load and start
    bus.ld = 1; bus.ld_val = 4'd3; bus.start = 1; bus.sweep = 1; bus.up_dn = 0;
    step(1);
    bus.ld = 0; bus.start = 0;
    wait_valid("load", DWELL);
    check("load code", int'(bus.code), 3);
    for (int i = 0; i < 3; i++) begin
      step(1);
      wait_valid("down", DWELL);
      check("down code", int'(bus.code), exp_dn[i]);
    end
    step(1);
    check("sweep done", int'(bus.done), 1);
    check("sweep valid", int'(bus.valid), 0);
    check("sweep wrap code", int'(bus.code), 9);
    step(1);
    check("done one cycle", int'(bus.done), 0);
    step(12);
    check("idle after sweep", int'(bus.valid), 0);

    // Back-pressure on code 5
    bus.sweep = 0; bus.up_dn = 1; bus.ready = 0;
    bus.ld = 1; bus.ld_val = 4'd5; bus.start = 1;
    step(1);
    bus.ld = 0; bus.start = 0;
    wait_valid("bp", DWELL);
    for (int i = 0; i < 25; i++) begin
      step(1);
      check("stall code", int'(bus.code), 5);
      check("stall valid", int'(bus.valid), 1);
    end
    bus.ready = 1;
    step(1);
    bus.ready = 0;
    check("release code", int'(bus.code), 6);
    check("release valid", int'(bus.valid), 0);

    // Load clamp in IDLE, load ignored in RUN
    bus.stop = 1;
    step(1);
    bus.stop = 0;
    bus.ld = 1; bus.ld_val = 4'hC;
    step(1);
    check("clamp C", int'(bus.code), 9);
    bus.ld_val = 4'd7;
    step(1);
    check("load 7", int'(bus.code), 7);
    bus.ld_val = 4'hF;
    step(1);
    bus.ld = 0;
    check("clamp F", int'(bus.code), 9);
    bus.start = 1;
    step(1);
    bus.start = 0;
    step(3);
    bus.ld = 1; bus.ld_val = 4'd2;
    step(2);
    bus.ld = 0;
    check("run ld ignored", int'(bus.code), 9);
    wait_valid("run ld", 0);
    check("run ld present", int'(bus.code), 9);

    // Stop together with ready while presenting 7
    bus.stop = 1;
    step(1);
    bus.stop = 0;
    bus.ld = 1; bus.ld_val = 4'd7; bus.start = 1;
    step(1);
    bus.ld = 0; bus.start = 0;
    wait_valid("pre stop", DWELL);
    check("pre stop code", int'(bus.code), 7);
    bus.stop = 1; bus.ready = 1;
    step(1);
    check("stop hs valid", int'(bus.valid), 0);
    check("stop hs code", int'(bus.code), 7);
    bus.start = 1;
    step(2);
    bus.start = 0; bus.stop = 0;
    step(12);
    check("stop beats start", int'(bus.valid), 0);
    bus.ready = 0;

    // Reset while holding code 4
    bus.ld = 1; bus.ld_val = 4'd4; bus.start = 1;
    step(1);
    bus.ld = 0; bus.start = 0;
    wait_valid("pre rst", DWELL);
    check("pre rst code", int'(bus.code), 4);
    rst = 1;
    step(1);
    rst = 0;
    check("mid rst code", int'(bus.code), 0);
    check("mid rst valid", int'(bus.valid), 0);
    check("mid rst done", int'(bus.done), 0);
    bus.start = 1;
    step(1);
    bus.start = 0;
    wait_valid("post rst", DWELL);
    check("post rst code", int'(bus.code), 0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
